fc_neuron_stream: RTL



---
 rtl/fc_pkg.sv | 37 +++
 rtl/fc_neuron_stream_if.sv | 32 +++
 rtl/fc_lane_sum.sv | 39 +++
 rtl/fc_neuron_stream.sv | 139 +++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the streamed neuron family (fc/pool/conv successors).
//   fc_state_t : control FSM states of the streamed neuron.
//   sat_signed : clamps a wide signed value to the range of a signed
//                field that is `width` bits wide (width <= SAT_MAX_W).
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        BIAS  = 2'd2,
        DONE  = 2'd3
    } fc_state_t;

    localparam int SAT_MAX_W = 128;

    function automatic logic signed [SAT_MAX_W-1:0] sat_signed(
        input logic signed [SAT_MAX_W-1:0] value,
        input int                          width
    );
        logic signed [SAT_MAX_W-1:0] one_v;
        logic signed [SAT_MAX_W-1:0] hi_v;
        logic signed [SAT_MAX_W-1:0] lo_v;
        logic signed [SAT_MAX_W-1:0] res_v;
        one_v = 128'sd1;
        hi_v  = (one_v <<< (width - 1)) - one_v;
        lo_v  = -(one_v <<< (width - 1));
        if (value > hi_v) begin
            res_v = hi_v;
        end else if (value < lo_v) begin
            res_v = lo_v;
        end else begin
            res_v = value;
        end
        return res_v;
    endfunction

endpackage

// File: rtl/fc_neuron_stream_if.sv
// Bus bundle of the streamed neuron: start strobe, input beat stream
// (in_valid/in_ready, in_data, w_data), bias, result stream
// (out_valid/out_ready, out_data) and busy status.
//   master : the feeding/consuming side (feature buffer + argmax).
//   slave  : the neuron itself.
interface fc_neuron_stream_if #(
    parameter int LANES = 1,
    parameter int IN_W  = 30,
    parameter int W_W   = 9,
    parameter int OUT_W = 38
);
    logic                    start;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*IN_W-1:0]   in_data;
    logic [LANES*W_W-1:0]    w_data;
    logic [W_W-1:0]          bias;
    logic [OUT_W-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;

    modport master (
        output start, in_valid, in_data, w_data, bias, out_ready,
        input  in_ready, out_data, out_valid, busy
    );

    modport slave (
        input  start, in_valid, in_data, w_data, bias, out_ready,
        output in_ready, out_data, out_valid, busy
    );
endinterface

// File: rtl/fc_lane_sum.sv
// Combinational dot product of one beat: LANES signed activation x weight
// products summed at full precision.
//   in_data : LANES x IN_W signed activations, lane 0 in the LSBs
//   w_data  : LANES x W_W signed weights, lane-aligned with in_data
//   sum     : signed sum, IN_W+W_W+$clog2(LANES)+1 bits (cannot overflow)
module fc_lane_sum #(
    parameter int LANES = 1,
    parameter int IN_W  = 30,
    parameter int W_W   = 9,
    localparam int PROD_W = IN_W + W_W,
    localparam int SUM_W  = IN_W + W_W + $clog2(LANES) + 1
) (
    input  logic [LANES*IN_W-1:0]   in_data,
    input  logic [LANES*W_W-1:0]    w_data,
    output logic signed [SUM_W-1:0] sum
);

    logic signed [IN_W-1:0]   a_s;
    logic signed [W_W-1:0]    b_s;
    logic signed [PROD_W-1:0] p_s;
    logic signed [SUM_W-1:0]  acc_s;

    // Multiply every lane and reduce the products into one signed sum.
    always_comb begin
        a_s   = '0;
        b_s   = '0;
        p_s   = '0;
        acc_s = '0;
        for (int k = 0; k < LANES; k++) begin
            a_s   = $signed(in_data[k*IN_W +: IN_W]);
            b_s   = $signed(w_data[k*W_W +: W_W]);
            p_s   = a_s * b_s;
            acc_s = acc_s + SUM_W'(p_s);
        end
    end

    assign sum = acc_s;

endmodule

// File: rtl/fc_neuron_stream.sv
// Streamed fully-connected neuron. Accumulates N_IN input/weight products,
// LANES per accepted beat, adds the bias, optionally applies ReLU and
// saturates to OUT_W bits.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : fc_neuron_stream_if slave (start, in_valid/in_ready, in_data,
//         w_data, bias, out_valid/out_ready, out_data, busy)
module fc_neuron_stream
    import fc_pkg::*;
#(
    parameter int N_IN  = 3136,
    parameter int LANES = 1,
    parameter int IN_W  = 30,
    parameter int W_W   = 9,
    parameter int OUT_W = 38,
    parameter int RELU  = 0
) (
    input  logic               clk,
    input  logic               rst,
    fc_neuron_stream_if.slave  bus
);

    localparam int ACC_W = IN_W + W_W + $clog2(N_IN);
    localparam int RES_W = ACC_W + 1;
    localparam int SUM_W = IN_W + W_W + $clog2(LANES) + 1;
    localparam int BEATS = N_IN / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if ((N_IN % LANES) != 0) begin : g_cfg_check
        $fatal(1, "fc_neuron_stream: N_IN must be a multiple of LANES");
    end

    fc_state_t                state_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [OUT_W-1:0]         out_data_r;
    logic                     out_valid_r;
    logic                     in_ready_r;
    logic                     busy_r;

    logic signed [SUM_W-1:0]  lane_sum_s;
    logic signed [W_W-1:0]    bias_s;
    logic signed [RES_W-1:0]  res_s;
    logic signed [RES_W-1:0]  relu_s;
    logic [OUT_W-1:0]         sat_s;

    fc_lane_sum #(
        .LANES (LANES),
        .IN_W  (IN_W),
        .W_W   (W_W)
    ) u_lane_sum (
        .in_data (bus.in_data),
        .w_data  (bus.w_data),
        .sum     (lane_sum_s)
    );

    assign bias_s = $signed(bus.bias);

    // Final result: accumulator plus bias, optional ReLU, clamp to OUT_W.
    always_comb begin
        res_s  = RES_W'(acc_r) + RES_W'(bias_s);
        relu_s = res_s;
        if ((RELU != 0) && res_s[RES_W-1]) begin
            relu_s = '0;
        end else begin
            relu_s = res_s;
        end
        sat_s = OUT_W'(sat_signed(SAT_MAX_W'(relu_s), OUT_W));
    end

    // Control FSM with accumulator, beat counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            cnt_r       <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r    <= ACCUM;
                        acc_r      <= '0;
                        cnt_r      <= '0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                ACCUM: begin
                    // in_ready_r mirrors the ACCUM state, so it gates acceptance.
                    if (bus.in_valid && in_ready_r) begin
                        acc_r <= acc_r + ACC_W'(lane_sum_s);
                        cnt_r <= cnt_r + 1'b1;
                        if (cnt_r == LAST_BEAT) begin
                            state_r    <= BIAS;
                            in_ready_r <= 1'b0;
                        end else begin
                            state_r    <= ACCUM;
                        end
                    end else begin
                        state_r <= ACCUM;
                    end
                end
                BIAS: begin
                    out_data_r  <= sat_s;
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;

endmodule
